// File: rtl/moore_seq_ctrl.sv
// Sequencing controller for the 0..LAST counting datapath: start/stop/pause control, valid/ready output, lap counting.
// Optional down-count support (dir port) is enabled by defining SEQ_DIR_EN.
module moore_seq_ctrl #(
  parameter int LAST  = 12,
  parameter int WIDTH = 5,
  parameter int LAPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [LAPW-1:0]  laps_in,
`ifdef SEQ_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] seq_out,
  output logic             seq_valid,
  input  logic             seq_ready,
  output logic             busy,
  output logic             done,
  output logic [LAPW-1:0]  lap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] C_LAST    = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] C_SEQ_ONE = WIDTH'(1);
  localparam logic [LAPW-1:0]  C_LAP_ONE = LAPW'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_seq;
  logic [WIDTH-1:0]  w_seq_next;
  logic [LAPW-1:0]   r_lap;
  logic [LAPW-1:0]   w_lap_next;
  logic [LAPW-1:0]   r_target;
  logic [LAPW-1:0]   w_target_next;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_dir;
  logic              w_at_wrap;
  logic              w_out_range;
  logic [LAPW-1:0]   w_lap_inc;
  logic              w_target_hit;
  logic [WIDTH-1:0]  w_seq_step;
  logic [WIDTH-1:0]  w_seq_wrap;
  logic [WIDTH-1:0]  w_seq_start;

`ifdef SEQ_DIR_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Wrap point and start value depend on direction; the lap boundary is the wrap itself.
  assign w_at_wrap    = w_dir ? (r_seq == '0) : (r_seq == C_LAST);
  assign w_seq_step   = w_dir ? (r_seq - C_SEQ_ONE) : (r_seq + C_SEQ_ONE);
  assign w_seq_wrap   = w_dir ? C_LAST : '0;
  assign w_seq_start  = w_dir ? C_LAST : '0;
  assign w_out_range  = (r_seq > C_LAST);
  assign w_lap_inc    = r_lap + C_LAP_ONE;
  assign w_target_hit = (r_target != '0) && (w_lap_inc == r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_seq    <= '0;
      r_lap    <= '0;
      r_target <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_seq    <= w_seq_next;
      r_lap    <= w_lap_next;
      r_target <= w_target_next;
      r_valid  <= (w_state_next == S_RUN);
      r_busy   <= (w_state_next == S_RUN) || (w_state_next == S_PAUSE);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_seq_next    = r_seq;
    w_lap_next    = r_lap;
    w_target_next = r_target;

    if (w_out_range) begin
      // Recovery from a corrupted sequence value.
      w_state_next = S_IDLE;
      w_seq_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_seq_next = '0;
          if (start && !stop) begin
            w_state_next  = S_RUN;
            w_target_next = laps_in;
            w_lap_next    = '0;
            w_seq_next    = w_seq_start;
          end
        end
        S_RUN: begin
          if (stop) begin
            w_state_next = S_IDLE;
            w_seq_next   = '0;
          end else if (pause) begin
            w_state_next = S_PAUSE;
          end else if (seq_ready) begin
            if (w_at_wrap) begin
              w_lap_next = w_lap_inc;
              if (w_target_hit) begin
                w_state_next = S_DONE;
                w_seq_next   = '0;
              end else begin
                w_seq_next = w_seq_wrap;
              end
            end else begin
              w_seq_next = w_seq_step;
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            w_state_next = S_IDLE;
            w_seq_next   = '0;
          end else if (!pause) begin
            w_state_next = S_RUN;
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
          w_seq_next   = '0;
        end
        default: begin
          w_state_next = S_IDLE;
          w_seq_next   = '0;
        end
      endcase
    end
  end

  assign seq_out   = r_seq;
  assign seq_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign lap_cnt   = r_lap;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Self-checking bench for moore_seq_ctrl: directed phases plus random control traffic against a cycle-level reference model.
module tb_moore_seq_ctrl;
  localparam int LAST  = 12;
  localparam int WIDTH = 5;
  localparam int LAPW  = 8;
  localparam int NVAL  = LAST + 1;

  logic             clk = 1'b0;
  logic             rst, start, stop, pause, seq_ready, dir;
  logic [LAPW-1:0]  laps_in;
  logic [WIDTH-1:0] seq_out;
  logic             seq_valid, busy, done;
  logic [LAPW-1:0]  lap_cnt;

  always #5 clk = ~clk;

  moore_seq_ctrl #(.LAST(LAST), .WIDTH(WIDTH), .LAPW(LAPW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .laps_in(laps_in),
`ifdef SEQ_DIR_EN
    .dir(dir),
`endif
    .seq_out(seq_out), .seq_valid(seq_valid), .seq_ready(seq_ready),
    .busy(busy), .done(done), .lap_cnt(lap_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: "phase" is idle/running/paused/finished, position and laps as plain integers.
  string m_phase = "idle";
  int    m_pos = 0;
  int    m_laps = 0;
  int    m_target = 0;
  int    exp_next = 0;
  int    done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL timeout_%s got=expired exp=reached", tag);
  endtask

  task automatic model_step(input logic [WIDTH-1:0] pre_out);
    bit down;
    down = (dir === 1'b1);
`ifndef SEQ_DIR_EN
    down = 1'b0;
`endif
    if (rst) begin
      m_phase = "idle"; m_pos = 0; m_laps = 0; m_target = 0;
    end else if (m_phase == "idle") begin
      m_pos = 0;
      if (start && !stop) begin
        m_phase = "run"; m_target = laps_in; m_laps = 0;
        m_pos = down ? LAST : 0;
        exp_next = m_pos;
      end
    end else if (m_phase == "finished") begin
      m_phase = "idle"; m_pos = 0;
    end else if (stop) begin
      m_phase = "idle"; m_pos = 0;
    end else if (pause) begin
      m_phase = "paused";
    end else if (m_phase == "paused") begin
      m_phase = "run";
    end else if (seq_ready) begin
      // Transfer: the accepted value must continue the sequence with nothing skipped or repeated.
      chk("xfer_order", 32'(pre_out), exp_next);
      exp_next = down ? (exp_next + LAST) % NVAL : (exp_next + 1) % NVAL;
      if (m_pos == (down ? 0 : LAST)) begin
        m_laps = (m_laps + 1) % (1 << LAPW);
        if (m_target != 0 && m_laps == m_target) begin
          m_phase = "finished"; m_pos = 0;
        end else begin
          m_pos = down ? LAST : 0;
        end
      end else begin
        m_pos = down ? m_pos - 1 : m_pos + 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit sp, input bit pa, input bit rd);
    logic [WIDTH-1:0] pre;
    rst = r; start = st; stop = sp; pause = pa; seq_ready = rd;
    pre = seq_out;
    @(posedge clk);
    model_step(pre);
    #1;
    chk("seq_out",   32'(seq_out),   m_pos);
    chk("seq_valid", 32'(seq_valid), (m_phase == "run") ? 1 : 0);
    chk("busy",      32'(busy),      (m_phase == "run" || m_phase == "paused") ? 1 : 0);
    chk("done",      32'(done),      (m_phase == "finished") ? 1 : 0);
    chk("lap_cnt",   32'(lap_cnt),   m_laps);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic run_until(input int pos, input int budget, input string tag);
    int n = 0;
    while (!(m_phase == "run" && m_pos == pos)) begin
      if (n >= budget) begin
        timeout(tag);
        return;
      end
      cyc(0, 0, 0, 0, 1);
      n++;
    end
  endtask

  initial begin
    dir = 1'b0; laps_in = '0;

    // Reset, then idle with no start.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, $urandom_range(0, 1));

    // Two laps with seq_ready held high.
    done_seen = 0;
    laps_in = 8'd2;
    cyc(0, 1, 0, 0, 1);
    repeat (30) cyc(0, 0, 0, 0, 1);
    chk("two_laps_done_pulses", 32'(done_seen), 1);
    chk("two_laps_final_laps", 32'(lap_cnt), 2);

    // Backpressure with a 3-cycle pause at seq_out=5.
    laps_in = 8'd1;
    cyc(0, 1, 0, 0, 0);
    begin
      int n = 0;
      while (!(m_phase == "run" && m_pos == 5) && n < 60) begin
        cyc(0, 0, 0, 0, $urandom_range(0, 1));
        n++;
      end
      if (n >= 60) timeout("reach5");
    end
    repeat (3) cyc(0, 0, 0, 1, 1);
    chk("pause_hold", 32'(seq_out), 5);
    begin
      int n = 0;
      while (m_phase != "idle" && n < 200) begin
        cyc(0, 0, 0, 0, $urandom_range(0, 1));
        n++;
      end
      if (n >= 200) timeout("bp_finish");
    end

    // Abort: stop, pause and start together at seq_out=7 in an endless run.
    done_seen = 0;
    laps_in = 8'd0;
    cyc(0, 1, 0, 0, 1);
    run_until(7, 40, "reach7");
    cyc(0, 1, 1, 1, 1);
    chk("abort_idle_busy", 32'(busy), 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("abort_no_done", 32'(done_seen), 0);

    // Reset mid-run at seq_out=9, then restart from 0.
    laps_in = 8'd3;
    cyc(0, 1, 0, 0, 1);
    run_until(9, 40, "reach9");
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("restart_zero", 32'(seq_out), 0);
    repeat (5) cyc(0, 0, 0, 0, 1);

`ifdef SEQ_DIR_EN
    // Down-count single lap: 12..0 then done.
    cyc(0, 0, 1, 0, 0);
    done_seen = 0;
    dir = 1'b1;
    laps_in = 8'd1;
    cyc(0, 1, 0, 0, 1);
    chk("down_start_last", 32'(seq_out), LAST);
    repeat (16) cyc(0, 0, 0, 0, 1);
    chk("down_done_pulses", 32'(done_seen), 1);
    chk("down_laps", 32'(lap_cnt), 1);
`endif

    // Random control traffic.
    for (int i = 0; i < 600; i++) begin
      laps_in = 8'($urandom_range(0, 3));
`ifdef SEQ_DIR_EN
      dir = 1'($urandom_range(0, 1));
`endif
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/moore_seq_ctrl.md
# moore_seq_ctrl

Sequencing controller for the team's 13-state Moore counting FSM datapath: runs the 0..LAST output sequence under start/stop/pause control instead of free-running it from reset. It adds an output valid/ready handshake, counts completed laps against a programmed target, and signals completion. It sits between the system control register block and the downstream consumer of the sequence value.

## Interface
- LAST, default 12: final sequence value; the sequence runs 0..LAST and then wraps to 0.
- WIDTH, default 5: width of `seq_out`; must satisfy LAST < 2^WIDTH.
- LAPW, default 8: width of the lap target and lap counter.

- clk  in  1  clock, rising edge.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- start  in  1  one-cycle pulse; in IDLE, latches `laps_in` and enters RUN.
- stop  in  1  one-cycle pulse; aborts RUN or PAUSE and returns to IDLE.
- pause  in  1  level; while high in RUN, the sequence holds (state PAUSE).
- laps_in  in  LAPW  number of full laps to run; 0 means run until stopped.
- dir  in  1  count direction, 0 = up, 1 = down; present only with SEQ_DIR_EN.
- seq_out  out  WIDTH  current sequence value, registered.
- seq_valid  out  1  `seq_out` is valid for the consumer.
- seq_ready  in  1  consumer accepts `seq_out` this cycle.
- busy  out  1  high in RUN and PAUSE.
- done  out  1  one-cycle pulse when the lap target is reached.
- lap_cnt  out  LAPW  number of laps completed in the current run.

## Operation
- States and encodings: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Outputs: seq_out=0, seq_valid=0, busy=0.
  - start → RUN; the lap target is latched from `laps_in` and lap_cnt clears to 0.
- RUN:
  - Outputs: seq_valid=1.
  - A beat transfers on `seq_valid & seq_ready`.
  - On transfer, seq_out advances by +1. If seq_out==LAST it wraps to 0 and lap_cnt increments by 1.
  - Once lap_cnt increments, if the target is nonzero and the new lap_cnt equals the target, the state goes to DONE. In that case seq_out goes to 0 instead of wrapping.
  - lap_cnt wraps modulo 2^LAPW when the target is 0.
- PAUSE:
  - Entered from RUN while pause=1.
  - Outputs: seq_valid=0; seq_out and lap_cnt hold.
  - pause=0 → RUN.
- DONE:
  - Outputs: done=1, seq_valid=0, busy=0; lap_cnt holds its final value.
  - Always → IDLE next cycle.
- Priority within a cycle: rst > stop > pause > transfer.
  - stop in RUN or PAUSE → IDLE next cycle; seq_out goes to 0 and lap_cnt holds; done is not asserted.
  - pause=1 in RUN blocks a transfer in the same cycle, even if seq_ready=1.
  - start in any state other than IDLE is ignored.
  - start and stop together in IDLE: stop wins, state stays IDLE.
- If seq_out is ever outside 0..LAST, the next cycle forces seq_out to 0 and the state to IDLE.

## Timing
- Reset values: state=IDLE, seq_out=0, seq_valid=0, busy=0, done=0, lap_cnt=0, lap target=0.
- Asserting rst mid-run aborts the run, with the same result as reset.
- start at edge N: RUN, seq_valid=1 and seq_out=0 are visible after edge N.
- Transfer at edge N: the new seq_out is visible after edge N, so one value per cycle with seq_ready held high.
- The final transfer of the last lap (seq_out=LAST) at edge N gives done=1 for the cycle after edge N, then IDLE after edge N+1.
- pause sampled high at edge N gives seq_valid=0 after edge N.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `SEQ_DIR_EN`.
- Defined:
  - The `dir` port exists.
  - With dir=1, a transfer moves seq_out by −1 and wraps from 0 to LAST, with the lap increment occurring on that wrap.
  - start with dir=1 loads seq_out=LAST instead of 0, and stop returns seq_out to 0.
  - The final-transfer rule mirrors up-count: in down-count the DONE-triggering transfer is from seq_out=0, and seq_out goes to 0 on entering DONE.
  - dir is sampled on every transfer.
- Not defined: the `dir` port is absent; count is up-only as described in Operation.

## Test plan
- Reset then idle: rst=1 for 2 cycles → all outputs 0; with start never pulsed, seq_out stays 0 and seq_valid stays 0 for 20 cycles.
- Two laps: laps_in=2, start, seq_ready=1 → seq_out 0..12,0..12 over 26 cycles; lap_cnt goes 1 then 2; done pulses for exactly 1 cycle; busy=0 afterwards.
- Backpressure and pause: seq_ready toggled 1/0 and pause high for 3 cycles at seq_out=5 → no values skipped or repeated in the transfer log, and seq_out holds at 5 through the pause.
- Abort: laps_in=0, stop at seq_out=7 with pause=1 and start in the same cycle → IDLE next cycle, seq_out=0, done is never asserted.
- Reset mid-run: rst during RUN at seq_out=9 → all reset values next cycle; a later start restarts from 0.
- With SEQ_DIR_EN: dir=1, laps_in=1 → seq_out 12..0, lap_cnt=1, then done.
